key_load_ctrl: RTL

- Upstream stage of the key-controlled, logic-locked c17 netlist.
- Receives the key as a serial bitstream and checks it with an even-parity bit.
- Presents the key as a parallel, glitch-free vector on the locked netlist's key inputs D_0..D_5.
- Only a complete, parity-correct key ever reaches the key inputs; until then the key vector is held at all-zero.

---
 rtl/key_load_pkg.sv | 15 +
 rtl/key_shift_reg.sv | 48 ++++
 rtl/key_load_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/key_load_pkg.sv
// Shared types and defaults for the serial key loader that feeds the locked c17 key inputs.
package key_load_pkg;

    localparam int KEY_W_DEF   = 6;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        LOCKED,
        ERROR
    } key_state_e;

endpackage

// File: rtl/key_shift_reg.sv
// Shadow register for the serial key: places bit n at shadow[n], counts bits and keeps a
// running even-parity accumulator that also absorbs the trailing parity bit.
module key_shift_reg
    import key_load_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic             clr,
    input  logic             bit_in,
    output logic [KEY_W-1:0] shadow,
    output logic             done,
    output logic             par_ok
);

    localparam int CNT_W = $clog2(KEY_W + 1);

    logic [CNT_W-1:0] bit_cnt;
    logic             par;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
        end else if (clr) begin
            shadow  <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
        end else if (load_en) begin
            par <= par ^ bit_in;
            // Once full, the counter saturates and the accepted bit is the parity bit.
            if (!done) begin
                for (int i = 0; i < KEY_W; i++) begin
                    if (bit_cnt == CNT_W'(i)) shadow[i] <= bit_in;
                end
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign done   = (bit_cnt == CNT_W'(KEY_W));
    assign par_ok = ~par;

endmodule

// File: rtl/key_load_ctrl.sv
// Serial key loader: shifts in a parity-protected key and only exposes it on key_out
// once complete and verified, so the locked netlist never sees a partial key.
module key_load_ctrl
    import key_load_pkg::*;
#(
    parameter int KEY_W   = KEY_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_start,
    input  logic             key_clear,
    input  logic             bit_valid,
    input  logic             bit_data,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             key_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    key_state_e       state, state_nxt;
    logic [TO_W-1:0]  to_cnt;
    logic [KEY_W-1:0] shadow;
    logic             done, par_ok;
    logic             start_acc, load_en, sr_clr, idle_tick, timeout_hit;

    // key_start is honoured everywhere except LOCKED and the single CHECK cycle.
    assign start_acc   = key_start && !key_clear && (state inside {IDLE, SHIFT, ERROR});
    assign load_en     = (state == SHIFT) && bit_valid && !key_start && !key_clear;
    assign sr_clr      = key_clear || start_acc;
    assign idle_tick   = (state == SHIFT) && !bit_valid && !key_start && !key_clear;
    assign timeout_hit = idle_tick && (to_cnt == TO_W'(TIMEOUT - 1));

    key_shift_reg #(.KEY_W(KEY_W)) u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_en(load_en),
        .clr    (sr_clr),
        .bit_in (bit_data),
        .shadow (shadow),
        .done   (done),
        .par_ok (par_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt is defaulted first so no path through this block can infer a latch.
    always_comb begin
        state_nxt = state;
        if (key_clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (key_start) state_nxt = SHIFT;
                SHIFT: begin
                    if (key_start)              state_nxt = SHIFT;
                    else if (bit_valid && done) state_nxt = CHECK;
                    else if (timeout_hit)       state_nxt = ERROR;
                end
                CHECK:   state_nxt = par_ok ? LOCKED : ERROR;
                LOCKED:  state_nxt = LOCKED;
                ERROR:   if (key_start) state_nxt = SHIFT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == SHIFT) || (state == CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (sr_clr || load_en) begin
            to_cnt <= '0;
        end else if (idle_tick && to_cnt != TO_W'(TIMEOUT)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // key_out is written only on the CHECK->LOCKED edge, so it is all-zero in every other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_out   <= '0;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
        end else if (key_clear) begin
            key_out   <= '0;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            if (start_acc)                                      key_err <= 1'b0;
            else if (timeout_hit || (state == CHECK && !par_ok)) key_err <= 1'b1;
            if (state == CHECK && par_ok) begin
                key_out   <= shadow;
                key_valid <= 1'b1;
            end
        end
    end

endmodule
